// File: rtl/lock_pkg.sv
// Shared constants for the lock sequencer: state encodings, display symbols and
// the code loaded at reset.
package lock_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_ENTRY    = 3'd1;
    localparam state_t ST_CHECK    = 3'd2;
    localparam state_t ST_OPEN     = 3'd3;
    localparam state_t ST_CHG_NEW  = 3'd4;
    localparam state_t ST_CHG_CONF = 3'd5;
    localparam state_t ST_LOCKOUT  = 3'd6;

    localparam logic [4:0] SYM_DASH  = 5'd16;
    localparam logic [4:0] SYM_BLANK = 5'd17;
    localparam logic [4:0] SYM_O     = 5'd18;
    localparam logic [4:0] SYM_P     = 5'd19;
    localparam logic [4:0] SYM_E     = 5'd20;
    localparam logic [4:0] SYM_N     = 5'd21;
    localparam logic [4:0] SYM_L     = 5'd22;

    localparam logic [15:0] DEFAULT_CODE = 16'h1234;

    function automatic logic [4:0] hex_sym(input logic [3:0] nib);
        return {1'b0, nib};
    endfunction

endpackage

// File: rtl/lock_ssd_fmt.sv
// Combinational formatter: turns the sequencer's next-state view into the
// four-symbol bus; the parent registers the result.
module lock_ssd_fmt
    import lock_pkg::*;
(
    input  logic [2:0]  state_i,
    input  logic [15:0] digits_i,
    input  logic [2:0]  cnt_i,
    input  logic [7:0]  timer_i,
    output logic [19:0] sym_o
);

    logic [15:0] aligned_s;

    // Left-justify the captured digits, then map them to symbols per state.
    always_comb begin
        sym_o     = {4{SYM_DASH}};
        aligned_s = 16'(digits_i << (5'd16 - {cnt_i, 2'b00}));
        case (state_i)
            ST_IDLE, ST_ENTRY, ST_CHG_NEW, ST_CHG_CONF: begin
                for (int i = 0; i < 4; i++) begin
                    if (i < int'(cnt_i)) begin
                        sym_o[19-5*i -: 5] = hex_sym(aligned_s[15-4*i -: 4]);
                    end else begin
                        sym_o[19-5*i -: 5] = SYM_DASH;
                    end
                end
            end
            ST_OPEN: begin
                sym_o = {SYM_O, SYM_P, SYM_E, SYM_N};
            end
            ST_LOCKOUT: begin
                sym_o = {SYM_L, SYM_BLANK, hex_sym(timer_i[7:4]), hex_sym(timer_i[3:0])};
            end
            default: begin
                sym_o = {4{SYM_DASH}};
            end
        endcase
    end

endmodule

// File: rtl/lock_sequencer.sv
// Lock FSM: code entry, verification, retry limiting, timed lockout and code
// change; all outputs are registered from the next-state values.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int          DIGITS        = 4,
    parameter int          MAX_TRIES     = 3,
    parameter int          LOCKOUT_TICKS = 10,
    parameter logic [15:0] DEFAULT_CODE  = lock_pkg::DEFAULT_CODE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        clr,
    input  logic        ent,
    input  logic        change,
    input  logic [3:0]  sw,
    output logic [5:0]  led,
    output logic [19:0] ssd,
    output logic        light
);

    state_t      state_q, state_d;
    logic [15:0] code_q, code_d;
    logic [15:0] buf_q, buf_d;
    logic [15:0] new_q, new_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  tries_q, tries_d;
    logic [7:0]  timer_q, timer_d;
    logic [5:0]  led_q, led_d;
    logic [19:0] ssd_q, ssd_d;
    logic        light_q, light_d;

    logic [2:0]  cnt_inc_s;
    logic        cnt_full_s;
    logic [15:0] buf_shift_s;
    logic [1:0]  tries_inc_s;
    logic [15:0] fmt_digits_s;
    logic [19:0] fmt_sym_s;

    assign cnt_inc_s   = cnt_q + 3'd1;
    assign cnt_full_s  = (cnt_inc_s == 3'(DIGITS));
    assign buf_shift_s = {buf_q[11:0], sw};
    assign tries_inc_s = tries_q + 2'd1;

    // Next-state logic; each branch tests clr, then ent, then change.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        buf_d   = buf_q;
        new_d   = new_q;
        cnt_d   = cnt_q;
        tries_d = tries_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE, ST_ENTRY: begin
                if (clr) begin
                    state_d = ST_IDLE;
                    buf_d   = 16'h0000;
                    cnt_d   = 3'd0;
                end else if (ent) begin
                    buf_d = buf_shift_s;
                    if (cnt_full_s) begin
                        state_d = ST_CHECK;
                        cnt_d   = 3'd0;
                    end else begin
                        state_d = ST_ENTRY;
                        cnt_d   = cnt_inc_s;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_CHECK: begin
                buf_d = 16'h0000;
                if (buf_q == code_q) begin
                    state_d = ST_OPEN;
                    tries_d = 2'd0;
                end else begin
                    tries_d = tries_inc_s;
                    if (tries_inc_s == 2'(MAX_TRIES)) begin
                        state_d = ST_LOCKOUT;
                        timer_d = 8'(LOCKOUT_TICKS);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_OPEN: begin
                if (clr) begin
                    state_d = ST_IDLE;
                    buf_d   = 16'h0000;
                    cnt_d   = 3'd0;
                end else if (ent) begin
                    state_d = ST_OPEN;
                end else if (change) begin
                    state_d = ST_CHG_NEW;
                    new_d   = 16'h0000;
                    cnt_d   = 3'd0;
                end else begin
                    state_d = ST_OPEN;
                end
            end
            ST_CHG_NEW, ST_CHG_CONF: begin
                if (clr) begin
                    state_d = ST_OPEN;
                    buf_d   = 16'h0000;
                    new_d   = 16'h0000;
                    cnt_d   = 3'd0;
                end else if (ent) begin
                    if (state_q == ST_CHG_NEW) begin
                        new_d = {new_q[11:0], sw};
                    end else begin
                        buf_d = buf_shift_s;
                    end
                    if (!cnt_full_s) begin
                        cnt_d = cnt_inc_s;
                    end else if (state_q == ST_CHG_NEW) begin
                        state_d = ST_CHG_CONF;
                        cnt_d   = 3'd0;
                    end else begin
                        // Commit only when the confirmation matches the new code.
                        if (buf_shift_s == new_q) begin
                            code_d = new_q;
                        end else begin
                            code_d = code_q;
                        end
                        state_d = ST_OPEN;
                        buf_d   = 16'h0000;
                        new_d   = 16'h0000;
                        cnt_d   = 3'd0;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOCKOUT: begin
                if (tick) begin
                    if (timer_q <= 8'd1) begin
                        state_d = ST_IDLE;
                        timer_d = 8'd0;
                        tries_d = 2'd0;
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end else begin
                    timer_d = timer_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                buf_d   = 16'h0000;
                new_d   = 16'h0000;
                cnt_d   = 3'd0;
            end
        endcase
    end

    assign fmt_digits_s = (state_d == ST_CHG_NEW) ? new_d : buf_d;

    lock_ssd_fmt u_fmt (
        .state_i  (state_d),
        .digits_i (fmt_digits_s),
        .cnt_i    (cnt_d),
        .timer_i  (timer_d),
        .sym_o    (fmt_sym_s)
    );

    // Output values for the coming cycle; CHECK keeps the previous display.
    always_comb begin
        led_d   = {(state_d == ST_OPEN), (state_d == ST_LOCKOUT), tries_d, cnt_d[1:0]};
        light_d = (state_d == ST_OPEN);
        if (state_d == ST_CHECK) begin
            ssd_d = ssd_q;
        end else begin
            ssd_d = fmt_sym_s;
        end
    end

    // State, code and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            code_q  <= DEFAULT_CODE;
            buf_q   <= 16'h0000;
            new_q   <= 16'h0000;
            cnt_q   <= 3'd0;
            tries_q <= 2'd0;
            timer_q <= 8'd0;
            led_q   <= 6'd0;
            ssd_q   <= {4{SYM_DASH}};
            light_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            buf_q   <= buf_d;
            new_q   <= new_d;
            cnt_q   <= cnt_d;
            tries_q <= tries_d;
            timer_q <= timer_d;
            led_q   <= led_d;
            ssd_q   <= ssd_d;
            light_q <= light_d;
        end
    end

    assign led   = led_q;
    assign ssd   = ssd_q;
    assign light = light_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer: hand-computed led/ssd/light values checked
// with immediate assertions after each step.
module tb_lock_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        clr;
    logic        ent;
    logic        change;
    logic [3:0]  sw;
    logic [5:0]  led;
    logic [19:0] ssd;
    logic        light;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [4:0] D  = 5'd16;
    localparam logic [4:0] B  = 5'd17;
    localparam logic [4:0] SO = 5'd18;
    localparam logic [4:0] SP = 5'd19;
    localparam logic [4:0] SE = 5'd20;
    localparam logic [4:0] SN = 5'd21;
    localparam logic [4:0] SL = 5'd22;

    localparam logic [19:0] DASHES = {D, D, D, D};
    localparam logic [19:0] OPEN_S = {SO, SP, SE, SN};

    lock_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .clr    (clr),
        .ent    (ent),
        .change (change),
        .sw     (sw),
        .led    (led),
        .ssd    (ssd),
        .light  (light)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle with the given pulses; returns at the next negedge.
    task automatic pulse(input logic c, input logic e, input logic ch, input logic t,
                         input logic [3:0] d);
        clr = c; ent = e; change = ch; tick = t; sw = d;
        @(negedge clk);
        clr = 1'b0; ent = 1'b0; change = 1'b0; tick = 1'b0;
    endtask

    task automatic enter4(input logic [15:0] code);
        for (int i = 0; i < 4; i++) begin
            pulse(1'b0, 1'b1, 1'b0, 1'b0, code[15-4*i -: 4]);
        end
    endtask

    // Enter a code from IDLE and pass through CHECK.
    task automatic try_code(input logic [15:0] code);
        enter4(code);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; clr = 1'b0; ent = 1'b0; change = 1'b0; sw = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_led", 20'(led), 20'h0);
        chk("rst_ssd", ssd, DASHES);
        chk("rst_light", 20'(light), 20'h0);
        rst = 1'b0;

        // Correct default code
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        chk("d1_led", 20'(led), 20'(6'b000001));
        chk("d1_ssd", ssd, {5'd1, D, D, D});
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
        chk("d3_ssd", ssd, {5'd1, 5'd2, 5'd3, D});
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
        chk("check_hold_ssd", ssd, {5'd1, 5'd2, 5'd3, D});
        chk("check_light", 20'(light), 20'h0);
        @(negedge clk);
        chk("open_led", 20'(led), 20'(6'b100000));
        chk("open_light", 20'(light), 20'h1);
        chk("open_ssd", ssd, OPEN_S);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("relock_led", 20'(led), 20'h0);

        // Three wrong codes; a tick during CHECK must not count
        try_code(16'h0000);
        chk("fail1_led", 20'(led), 20'(6'b000100));
        try_code(16'h0000);
        chk("fail2_led", 20'(led), 20'(6'b001000));
        enter4(16'h0000);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        chk("lock_led", 20'(led), 20'(6'b011100));
        chk("lock_ssd", ssd, {SL, B, 5'd0, 5'd10});
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd5);
        pulse(1'b1, 1'b0, 1'b1, 1'b0, 4'd5);
        chk("lock_ent_led", 20'(led), 20'(6'b011100));
        chk("lock_ent_ssd", ssd, {SL, B, 5'd0, 5'd10});
        repeat (3) pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        chk("lock_t3_ssd", ssd, {SL, B, 5'd0, 5'd7});
        repeat (6) pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        chk("lock_t9_ssd", ssd, {SL, B, 5'd0, 5'd1});
        chk("lock_t9_led", 20'(led), 20'(6'b011100));
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        chk("unlock_led", 20'(led), 20'h0);
        chk("unlock_ssd", ssd, DASHES);

        // Successful code change to 9876
        try_code(16'h1234);
        chk("open2_light", 20'(light), 20'h1);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        chk("chg_led", 20'(led), 20'h0);
        chk("chg_ssd", ssd, DASHES);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd9);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd8);
        chk("chg2_led", 20'(led), 20'(6'b000010));
        chk("chg2_ssd", ssd, {5'd9, 5'd8, D, D});
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd7);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd6);
        enter4(16'h9876);
        chk("chg_done_led", 20'(led), 20'(6'b100000));
        chk("chg_done_ssd", ssd, OPEN_S);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        try_code(16'h9876);
        chk("new_code_light", 20'(light), 20'h1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        try_code(16'h1234);
        chk("old_code_led", 20'(led), 20'(6'b000100));
        try_code(16'h9876);
        chk("new_code2_led", 20'(led), 20'(6'b100000));

        // Mismatched confirmation leaves code unchanged
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        enter4(16'h9876);
        enter4(16'h9875);
        chk("mis_conf_led", 20'(led), 20'(6'b100000));
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        try_code(16'h9875);
        chk("mis_new_led", 20'(led), 20'(6'b000100));
        try_code(16'h9876);
        chk("mis_keep_light", 20'(light), 20'h1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

        // clr wins over ent in the same cycle
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
        chk("two_led", 20'(led), 20'(6'b000010));
        pulse(1'b1, 1'b1, 1'b0, 1'b0, 4'd3);
        chk("clr_ent_led", 20'(led), 20'h0);
        chk("clr_ent_ssd", ssd, DASHES);

        // Reset during lockout, after a changed code
        try_code(16'h0000);
        try_code(16'h0000);
        try_code(16'h0000);
        chk("lock2_led", 20'(led), 20'(6'b011100));
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
        do_reset();
        chk("rst2_led", 20'(led), 20'h0);
        chk("rst2_ssd", ssd, DASHES);
        chk("rst2_light", 20'(light), 20'h0);
        try_code(16'h9876);
        chk("rst2_oldchg_led", 20'(led), 20'(6'b000100));
        try_code(16'h1234);
        chk("rst2_default_light", 20'(light), 20'h1);

        // Reset mid-entry clears the partial display
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd7);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd7);
        do_reset();
        chk("rst3_led", 20'(led), 20'h0);
        chk("rst3_ssd", ssd, DASHES);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
